// File: rtl/uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_stream
// Description : 8N1 UART transmitter fed by a byte FIFO. Bytes pushed with a
//               valid/ready handshake are queued and then shifted out LSB
//               first, with a start bit (0) and a stop bit (1). Each bit lasts
//               DIVISOR = CLK_FREQ_HZ / BAUD_RATE clocks. Queued bytes go out
//               back to back with no idle time between frames.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_FREQ_HZ : input clock frequency in Hz
//   BAUD_RATE   : serial line rate in bit/s
//   FIFO_DEPTH  : number of FIFO entries (power of two, >= 2)
// Ports
//   clock      in   system clock, rising edge
//   resetb     in   asynchronous active-low reset
//   tx_valid   in   a byte is offered on tx_data
//   tx_data    in   byte to transmit
//   tx_ready   out  FIFO can accept a byte (FIFO not full)
//   tx         out  serial line, idle high, registered
//   busy       out  FSM not idle or FIFO non-empty
//   fifo_count out  bytes queued in the FIFO (the byte being shifted is not
//                   counted)
// ============================================================================
module uart_tx_stream #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIVISOR = CLK_FREQ_HZ / BAUD_RATE;
  // Counter width for 0..DIVISOR-1; guarded so a bad DIVISOR still elaborates
  // far enough to reach the parameter check below.
  localparam int DIV_W   = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
  localparam int AW      = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("uart_tx_stream: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_stream: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic              w_tc;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_push;
  logic              w_pop;
  logic [7:0]        w_head;

  assign w_tc         = (r_div == DIV_W'(DIVISOR - 1));
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_push       = tx_valid && !w_fifo_full;
  // The shifter takes a new byte either straight from IDLE or at the end of
  // a stop bit, which is what makes consecutive frames gapless.
  assign w_pop        = !w_fifo_empty &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tc));
  assign w_head       = r_mem[r_rd_ptr];

  // --------------------------------------------------------------------------
  // FIFO storage (no reset needed; pointers and count define validity)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx  <= 1'b1;
          r_div <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_tc) begin
            r_div   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_DATA: begin
          if (w_tc) begin
            r_div <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              // r_shift[1] becomes the new LSB after the shift.
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_STOP: begin
          if (w_tc) begin
            r_div <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_bit   <= '0;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_div   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tx         = r_tx;
  assign tx_ready   = !w_fifo_full;
  assign busy       = (r_state != S_IDLE) || !w_fifo_empty;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_stream
// Description : Directed self-checking bench for uart_tx_stream. Instance A
//               uses the default 100 MHz / 115200 baud settings; instance B
//               uses 1 MHz / 100 kbaud (10 clocks per bit) for the longer
//               scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stream;

  localparam int DA = 868;
  localparam int DB = 10;

  logic       clk;
  logic       rstn_a, valid_a, ready_a, tx_a, busy_a;
  logic [7:0] data_a;
  logic [4:0] cnt_a;
  logic       rstn_b, valid_b, ready_b, tx_b, busy_b;
  logic [7:0] data_b;
  logic [4:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_stream u_dut_a (
    .clock      (clk),
    .resetb     (rstn_a),
    .tx_valid   (valid_a),
    .tx_data    (data_a),
    .tx_ready   (ready_a),
    .tx         (tx_a),
    .busy       (busy_a),
    .fifo_count (cnt_a)
  );

  uart_tx_stream #(
    .CLK_FREQ_HZ (1000000),
    .BAUD_RATE   (100000),
    .FIFO_DEPTH  (16)
  ) u_dut_b (
    .clock      (clk),
    .resetb     (rstn_b),
    .tx_valid   (valid_b),
    .tx_data    (data_b),
    .tx_ready   (ready_b),
    .tx         (tx_b),
    .busy       (busy_b),
    .fifo_count (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one frame cycle by cycle starting at frame cycle 'first' (0 = first
  // cycle of the start bit); compares every cycle's line level, decodes the
  // byte at mid-bit, and counts busy cycles. Leaves the bench at the first
  // cycle after the stop bit.
  task automatic check_frame(input int sel, input int div, input logic [7:0] exp,
                             input int first, input string tag);
    int         mism;
    int         bsy;
    int         b;
    logic [7:0] dec;
    logic [9:0] frame;
    mism  = 0;
    bsy   = 0;
    dec   = '0;
    frame = {1'b1, exp, 1'b0};
    for (int i = first; i < 10 * div; i++) begin
      b = i / div;
      if (get_tx(sel) !== frame[b]) mism++;
      if (get_busy(sel) === 1'b1) bsy++;
      if (((i % div) == div / 2) && (b >= 1) && (b <= 8)) dec[b-1] = get_tx(sel);
      tick();
    end
    $display("%s: Got %c", tag, dec);
    chk({tag, " level errors"}, mism, 0);
    chk({tag, " decoded"}, dec, exp);
    chk({tag, " busy cycles"}, bsy, 10 * div - first);
  endtask

  // Mid-bit receiver: waits (bounded) for a start bit, then samples each bit.
  task automatic rx_byte(input int sel, input int div, output logic [7:0] d, output logic ok);
    int w;
    w  = 0;
    ok = 1'b1;
    d  = '0;
    while ((get_tx(sel) !== 1'b0) && (w < 30 * div)) begin
      tick();
      w++;
    end
    if (w >= 30 * div) ok = 1'b0;
    repeat (div / 2) tick();
    if (get_tx(sel) !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (div) tick();
      d[k] = get_tx(sel);
    end
    repeat (div) tick();
    if (get_tx(sel) !== 1'b1) ok = 1'b0;
  endtask

  int         acc;
  int         cyc;
  int         tacc [20];
  int         bad;
  logic       w_rdy;
  logic [7:0] rx_d;
  logic       rx_ok;

  initial begin
    rstn_a  = 1'b0;
    rstn_b  = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = '0;
    data_b  = '0;
    repeat (3) tick();

    // ---------------- reset values ----------------
    chk("reset tx", tx_a, 1);
    chk("reset tx_ready", ready_a, 1);
    chk("reset busy", busy_a, 0);
    chk("reset fifo_count", cnt_a, 0);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    repeat (2) tick();
    chk("idle tx after release", tx_a, 1);

    // ---------------- single byte 0x37, defaults ----------------
    valid_a = 1'b1;
    data_a  = 8'h37;
    tick();                             // accept edge
    valid_a = 1'b0;
    chk("b37 count after accept", cnt_a, 1);
    chk("b37 tx idle at accept", tx_a, 1);
    chk("b37 busy at accept", busy_a, 1);
    tick();                             // pop edge: start bit begins
    chk("b37 start one cycle later", tx_a, 0);
    chk("b37 count after pop", cnt_a, 0);
    check_frame(0, DA, 8'h37, 0, "b37");
    chk("b37 busy after frame", busy_a, 0);
    chk("b37 tx after frame", tx_a, 1);

    // ---------------- back to back ABC ----------------
    // The first byte leaves the FIFO on the second edge while 'B' arrives,
    // so the count reads 1, 1, 2.
    valid_a = 1'b1;
    data_a  = 8'h41;
    tick();
    chk("abc count e0", cnt_a, 1);
    data_a = 8'h42;
    tick();
    chk("abc count e1", cnt_a, 1);
    chk("abc start e1", tx_a, 0);
    data_a = 8'h43;
    tick();
    chk("abc count e2", cnt_a, 2);
    valid_a = 1'b0;
    check_frame(0, DA, 8'h41, 1, "abc A");
    chk("abc count after A", cnt_a, 1);
    check_frame(0, DA, 8'h42, 0, "abc B");
    chk("abc count after B", cnt_a, 0);
    check_frame(0, DA, 8'h43, 0, "abc C");
    chk("abc busy end", busy_a, 0);

    // ---------------- DIVISOR=10, byte 0xA5 ----------------
    valid_b = 1'b1;
    data_b  = 8'hA5;
    tick();
    valid_b = 1'b0;
    chk("a5 count", cnt_b, 1);
    tick();
    chk("a5 start", tx_b, 0);
    check_frame(1, DB, 8'hA5, 0, "a5");
    chk("a5 busy end", busy_b, 0);

    // ---------------- fill with valid held high ----------------
    fork
      begin
        valid_b = 1'b1;
        data_b  = 8'h00;
        acc     = 0;
        cyc     = 0;
        while ((acc < 20) && (cyc < 3000)) begin
          w_rdy = ready_b;
          tick();
          cyc++;
          if (w_rdy) begin
            tacc[acc] = cyc;
            acc++;
            data_b = data_b + 8'd1;
          end
          if (cyc == 60) begin
            chk("fill accepted before full", acc, 17);
            chk("fill tx_ready low", ready_b, 0);
            chk("fill count full", cnt_b, 16);
          end
        end
        valid_b = 1'b0;
        chk("fill total accepted", acc, 20);
        chk("fill spacing 17-18", tacc[18] - tacc[17], 10 * DB);
        chk("fill spacing 18-19", tacc[19] - tacc[18], 10 * DB);
      end
      begin
        bad = 0;
        for (int k = 0; k < 20; k++) begin
          rx_byte(1, DB, rx_d, rx_ok);
          if (!rx_ok || (rx_d !== 8'(k))) bad++;
        end
        chk("fill bytes in order", bad, 0);
      end
    join
    cyc = 0;
    while ((busy_b !== 1'b0) && (cyc < 100)) begin
      tick();
      cyc++;
    end
    chk("fill drained", busy_b, 0);

    // ---------------- simultaneous push and pop ----------------
    valid_b = 1'b1;
    data_b  = 8'h10;
    tick();
    data_b = 8'h11;
    tick();                             // frame for 0x10 starts here
    data_b = 8'h12;
    tick();
    data_b = 8'h13;
    tick();
    valid_b = 1'b0;
    chk("pp count before", cnt_b, 3);
    repeat (10 * DB - 3) tick();        // last cycle of the stop bit
    chk("pp stop level", tx_b, 1);
    valid_b = 1'b1;
    data_b  = 8'h14;
    tick();                             // stop terminal count: push + pop
    valid_b = 1'b0;
    chk("pp count unchanged", cnt_b, 3);
    chk("pp next start no gap", tx_b, 0);
    check_frame(1, DB, 8'h11, 0, "pp 11");
    check_frame(1, DB, 8'h12, 0, "pp 12");
    check_frame(1, DB, 8'h13, 0, "pp 13");
    check_frame(1, DB, 8'h14, 0, "pp 14");
    chk("pp busy end", busy_b, 0);

    // ---------------- reset mid-frame ----------------
    valid_b = 1'b1;
    data_b  = 8'h0F;
    tick();
    data_b = 8'h3C;
    tick();                             // frame for 0x0F starts
    data_b = 8'h99;
    tick();
    valid_b = 1'b0;
    repeat (5 * DB + 2) tick();         // inside data bit 4
    chk("rst bit4 level", tx_b, 0);
    chk("rst count before", cnt_b, 2);
    #1;
    rstn_b = 1'b0;
    #1;
    chk("rst tx async high", tx_b, 1);
    chk("rst count flushed", cnt_b, 0);
    chk("rst busy low", busy_b, 0);
    chk("rst tx_ready high", ready_b, 1);
    repeat (2) tick();
    rstn_b = 1'b1;
    repeat (3) tick();
    chk("rst no resumption", tx_b, 1);
    valid_b = 1'b1;
    data_b  = 8'h55;
    tick();
    valid_b = 1'b0;
    tick();
    check_frame(1, DB, 8'h55, 0, "rst 55");
    chk("rst busy end", busy_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
